dram_access_sched: RTL

Front-end scheduler for `dram_ctrl_fsm`. It shares the single controller among `NUM_REQ` requesters using round-robin arbitration. It also owns the periodic refresh timer, so `refresh_flag` is raised only between accesses and never in the middle of one. The block latches the winning requester's bank/row/offset and holds `addr_val` until the controller reports completion.

---
 rtl/dram_access_sched_pkg.sv | 25 ++
 rtl/dram_access_sched_if.sv | 38 +++
 rtl/dram_access_sched_rr_arbiter.sv | 32 +++
 rtl/dram_access_sched.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/dram_access_sched_pkg.sv
// Shared definitions for the DRAM access scheduler and the DRAM controller FSM.
// Latency: n/a (types, constants and constant functions only).
// Backpressure: n/a.
package dram_pkg;

  // Scheduler states
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCESS  = 2'd1,
    S_REFRESH = 2'd2
  } state_t;

  localparam int DEFAULT_REFRESH_INTERVAL = 780;

  // Bank id width for a given bank count (never below one bit)
  function automatic int bank_w(input int nbanks);
    return (nbanks > 1) ? $clog2(nbanks) : 1;
  endfunction

  // Row id width for a given row count (never below one bit)
  function automatic int row_w(input int nrows);
    return (nrows > 1) ? $clog2(nrows) : 1;
  endfunction

endpackage

// File: rtl/dram_access_sched_if.sv
// Requester and controller signal bundle for the DRAM access scheduler.
// Latency: n/a (wires only).
// Backpressure: req is a level held until gnt; access ends on ctrl_done, refresh on ref_done.
interface dram_access_sched_if
  import dram_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int BW       = bank_w(8),
  parameter int RW       = row_w(128),
  parameter int OFFSET_W = 10
);
  logic [NUM_REQ-1:0]          req;
  logic [NUM_REQ*BW-1:0]       req_bank;
  logic [NUM_REQ*RW-1:0]       req_row;
  logic [NUM_REQ*OFFSET_W-1:0] req_offset;
  logic [NUM_REQ-1:0]          gnt;
  logic [NUM_REQ-1:0]          done;
  logic                        addr_val;
  logic [BW-1:0]               bank_id;
  logic [RW-1:0]               row_id;
  logic [OFFSET_W-1:0]         offset;
  logic                        ctrl_done;
  logic                        refresh_flag;
  logic                        ref_done;
  logic                        ref_overrun;

  // Scheduler side
  modport slave (
    input  req, req_bank, req_row, req_offset, ctrl_done, ref_done,
    output gnt, done, addr_val, bank_id, row_id, offset, refresh_flag, ref_overrun
  );

  // Requesters plus controller side
  modport master (
    output req, req_bank, req_row, req_offset, ctrl_done, ref_done,
    input  gnt, done, addr_val, bank_id, row_id, offset, refresh_flag, ref_overrun
  );
endinterface

// File: rtl/dram_access_sched_rr_arbiter.sv
// Round-robin pick: first asserted request at or after rr_ptr, wrapping.
// Latency: combinational.
// Backpressure: none; the caller decides when the winner is consumed.
module dram_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      rr_ptr_i,
  output logic [NUM_REQ-1:0] win_o,
  output logic [IW-1:0]      win_idx_o,
  output logic               win_vld_o
);

  // Scan from rr_ptr upward, modulo NUM_REQ, and keep the first hit
  always_comb begin
    int idx;
    idx       = 0;
    win_o     = '0;
    win_idx_o = '0;
    win_vld_o = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr_i) + k) % NUM_REQ;
      if (!win_vld_o && req_i[idx]) begin
        win_vld_o  = 1'b1;
        win_idx_o  = IW'(idx);
        win_o[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dram_access_sched.sv
// Shares one DRAM controller among NUM_REQ requesters (round robin) and owns the refresh timer.
// Latency: gnt/addr_val one cycle after req is sampled idle; done one cycle after ctrl_done.
// Backpressure: one access or refresh in flight; requesters hold req until gnt, refresh waits for idle.
module dram_access_sched
  import dram_pkg::*;
#(
  parameter int NUM_REQ          = 4,
  parameter int NUMBER_OF_BANKS  = 8,
  parameter int NUMBER_OF_ROWS   = 128,
  parameter int OFFSET_W         = 10,
  parameter int REFRESH_INTERVAL = DEFAULT_REFRESH_INTERVAL
) (
  input logic               clk,
  input logic               rst_b,
  dram_access_sched_if.slave bus
);

  localparam int BW  = bank_w(NUMBER_OF_BANKS);
  localparam int RW  = row_w(NUMBER_OF_ROWS);
  localparam int RW1 = RW + 1;
  localparam int IW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW  = $clog2(REFRESH_INTERVAL);
  localparam int CW  = (OFFSET_W > RW1) ? OFFSET_W : RW1;

  localparam logic [TW-1:0]  RELOAD   = TW'(REFRESH_INTERVAL - 1);
  localparam logic [RW1-1:0] LAST_ROW = RW1'(NUMBER_OF_ROWS - 1);

  state_t               state_q;
  logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]        cur_q;
  logic [NUM_REQ-1:0]   gnt_q, done_q;
  logic                 addr_val_q, refresh_q;
  logic [BW-1:0]        bank_q;
  logic [RW-1:0]        row_q;
  logic [OFFSET_W-1:0]  off_q, off_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic                 ref_pend_q, ref_pend_d;
  logic                 overrun_q, overrun_d;

  logic [NUM_REQ-1:0]   win;
  logic [IW-1:0]        win_idx;
  logic                 win_vld;
  logic [BW-1:0]        win_bank;
  logic [RW-1:0]        win_row;
  logic [OFFSET_W-1:0]  win_off;
  logic                 ref_clr;

  dram_rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_arb (
    .req_i     (bus.req),
    .rr_ptr_i  (rr_ptr_q),
    .win_o     (win),
    .win_idx_o (win_idx),
    .win_vld_o (win_vld)
  );

  assign win_bank = bus.req_bank[win_idx*BW +: BW];
  assign win_row  = bus.req_row[win_idx*RW +: RW];
  assign win_off  = bus.req_offset[win_idx*OFFSET_W +: OFFSET_W];
  assign ref_clr  = (state_q == S_REFRESH) && bus.ref_done;
  assign rr_ptr_d = (cur_q == IW'(NUM_REQ - 1)) ? '0 : cur_q + IW'(1);

  // Clamp the row count so the access never runs past the last row of the bank
  always_comb begin
    logic [RW1-1:0] room;
    logic [CW-1:0]  room_c, off_c;
    room   = LAST_ROW - {1'b0, win_row};
    room_c = CW'(room);
    off_c  = CW'(win_off);
    off_d  = (off_c > room_c) ? OFFSET_W'(room_c) : win_off;
  end

  // Refresh timer next state: expiry raises ref_pend; a second expiry while pending is an overrun
  always_comb begin
    timer_d    = timer_q - TW'(1);
    ref_pend_d = ref_pend_q;
    overrun_d  = overrun_q;
    if (timer_q == '0) begin
      timer_d    = RELOAD;
      ref_pend_d = 1'b1;
      if (ref_pend_q && !ref_clr) overrun_d = 1'b1;
    end else if (ref_clr) begin
      ref_pend_d = 1'b0;
    end
  end

  // Refresh timer, pending and sticky overrun registers
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      timer_q    <= RELOAD;
      ref_pend_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      timer_q    <= timer_d;
      ref_pend_q <= ref_pend_d;
      overrun_q  <= overrun_d;
    end
  end

  // Scheduler FSM with registered grant, completion, access fields and refresh request
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= '0;
      cur_q      <= '0;
      gnt_q      <= '0;
      done_q     <= '0;
      addr_val_q <= 1'b0;
      refresh_q  <= 1'b0;
      bank_q     <= '0;
      row_q      <= '0;
      off_q      <= '0;
    end else begin
      gnt_q  <= '0;
      done_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (ref_pend_q) begin
            refresh_q <= 1'b1;
            state_q   <= S_REFRESH;
          end else if (win_vld) begin
            cur_q      <= win_idx;
            gnt_q      <= win;
            addr_val_q <= 1'b1;
            bank_q     <= win_bank;
            row_q      <= win_row;
            off_q      <= off_d;
            state_q    <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (bus.ctrl_done) begin
            addr_val_q <= 1'b0;
            done_q     <= NUM_REQ'(1) << cur_q;
            rr_ptr_q   <= rr_ptr_d;
            state_q    <= S_IDLE;
          end
        end
        S_REFRESH: begin
          if (bus.ref_done) begin
            refresh_q <= 1'b0;
            state_q   <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.gnt          = gnt_q;
  assign bus.done         = done_q;
  assign bus.addr_val     = addr_val_q;
  assign bus.bank_id      = bank_q;
  assign bus.row_id       = row_q;
  assign bus.offset       = off_q;
  assign bus.refresh_flag = refresh_q;
  assign bus.ref_overrun  = overrun_q;

endmodule
